// File: rtl/seq_control.sv
// rtl/seq_control.sv - control FSM for the bit-scan data path (load, four even-bit scan steps, done/ack, watchdog)
module seq_control #(
    parameter int MAX_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       ack,
    input  logic       b,
    input  logic       it_end,
    output logic       y_en,
    output logic       y_store_x,
    output logic [1:0] y_select_next,
    output logic       s_en,
    output logic       s_zero,
    output logic       s_add,
    output logic [1:0] s_step,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPER = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // y input selector codes
    localparam logic [1:0] SEL_HOLD  = 2'd0;
    localparam logic [1:0] SEL_PLUS  = 2'd2;
    localparam logic [1:0] SEL_MINUS = 2'd3;

    localparam logic [2:0] MAX_CNT = 3'(MAX_STEPS);

    state_t     state;
    logic [2:0] step_cnt;
    logic       err_q;
    logic       trip;

    // Watchdog fires when the scan has used its full step budget without reaching the end
    assign trip = (state == OPER) && !it_end && (step_cnt == MAX_CNT);

    // State, step counter and sticky error register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            step_cnt <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= OPER;
                        step_cnt <= 3'd0;
                        err_q    <= 1'b0;
                    end
                end
                OPER: begin
                    if (trip) begin
                        err_q <= 1'b1;
                        state <= ERR;
                    end else if (it_end) begin
                        state <= DONE;
                    end else begin
                        step_cnt <= step_cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Control strobes decoded from state and inputs; reset forces every output low
    always_comb begin
        y_en          = 1'b0;
        y_store_x     = 1'b0;
        y_select_next = SEL_HOLD;
        s_en          = 1'b0;
        s_zero        = 1'b0;
        s_add         = 1'b0;
        s_step        = 2'd0;
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        if (!rst) begin
            err = err_q;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        y_en      = 1'b1;
                        y_store_x = 1'b1;
                        s_en      = 1'b1;
                        s_zero    = 1'b1;
                        s_add     = 1'b1;
                    end
                end
                OPER: begin
                    busy = 1'b1;
                    if (!trip) begin
                        y_en          = 1'b1;
                        y_select_next = b ? SEL_MINUS : SEL_PLUS;
                        if (!it_end) begin
                            s_en   = 1'b1;
                            s_add  = 1'b1;
                            s_step = 2'd2;
                        end
                    end
                end
                DONE: begin
                    done = 1'b1;
                end
                ERR: begin
                    err = 1'b1;
                end
                default: begin
                    err = err_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_control.sv
// tb/tb_seq_control.sv - self-checking bench for seq_control with a data-path model and reference function
module tb_seq_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       ack;
    logic       b;
    logic       it_end;
    logic       y_en;
    logic       y_store_x;
    logic [1:0] y_select_next;
    logic       s_en;
    logic       s_zero;
    logic       s_add;
    logic [1:0] s_step;
    logic       busy;
    logic       done;
    logic       err;

    logic [7:0] x = 8'h00;
    logic [7:0] dp_y = 8'hAA;
    logic [2:0] dp_s = 3'd0;
    logic       force_low = 1'b0;

    int total = 0;
    int passed = 0;

    seq_control #(.MAX_STEPS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .ack(ack), .b(b), .it_end(it_end),
        .y_en(y_en), .y_store_x(y_store_x), .y_select_next(y_select_next),
        .s_en(s_en), .s_zero(s_zero), .s_add(s_add), .s_step(s_step),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    wire [11:0] outs = {y_en, y_store_x, y_select_next, s_en, s_zero, s_add, s_step, busy, done, err};

    // Data-path model driven by the strobes; supplies the status inputs
    assign b      = dp_y[dp_s];
    assign it_end = (dp_s == 3'd6) && !force_low;

    always @(posedge clk) begin
        logic [2:0] base;
        base = s_zero ? 3'd0 : dp_s;
        if (y_en) begin
            if (y_store_x) dp_y <= x;
            else case (y_select_next)
                2'd1:    dp_y <= dp_y + 8'd1;
                2'd2:    dp_y <= dp_y + {5'd0, dp_s};
                2'd3:    dp_y <= dp_y - {5'd0, dp_s};
                default: dp_y <= dp_y;
            endcase
        end
        if (s_en) dp_s <= s_add ? base + {1'b0, s_step} : base - {1'b0, s_step};
    end

    function automatic logic [11:0] mk(input logic ye, input logic ys, input logic [1:0] sel,
                                       input logic se, input logic sz, input logic sa,
                                       input logic [1:0] st, input logic bz, input logic dn,
                                       input logic er);
        return {ye, ys, sel, se, sz, sa, st, bz, dn, er};
    endfunction

    // Reference: scan s = 0,2,4,6; subtract s if y[s] set, else add; record the chosen select
    function automatic logic [15:0] ref_run(input logic [7:0] xv);
        logic [7:0] y;
        logic [7:0] sels;
        y = xv;
        sels = 8'd0;
        for (int k = 0; k < 4; k++) begin
            int s;
            s = 2 * k;
            if (y[s]) begin
                sels[2*k +: 2] = 2'd3;
                y = y - 8'(s);
            end else begin
                sels[2*k +: 2] = 2'd2;
                y = y + 8'(s);
            end
        end
        return {sels, y};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] xv, input int ack_dly, input bit poke, input logic err_before);
        logic [15:0] r;
        int busy_n;
        r = ref_run(xv);
        busy_n = 0;
        tick(); x = xv; start = 1'b1; ack = 1'b0; #1;
        check("start_strobes", outs, mk(1, 1, 2'd0, 1, 1, 1, 2'd0, 0, 0, err_before));
        for (int i = 0; i < 4; i++) begin
            tick(); x = 8'($urandom); start = poke ? 1'($urandom_range(0, 1)) : 1'b0; #1;
            busy_n += int'(busy);
            check("oper_strobes", outs, mk(1, 0, r[8 + 2*i +: 2], i < 3, 0, i < 3,
                                           (i < 3) ? 2'd2 : 2'd0, 1, 0, 0));
        end
        tick(); start = 1'b0; x = 8'($urandom); #1;
        check("done_vec", outs, mk(0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0));
        check("busy_cycles", busy_n, 4);
        check("result_y", dp_y, r[7:0]);
        for (int i = 0; i < ack_dly; i++) begin
            tick(); start = poke ? 1'($urandom_range(0, 1)) : 1'b0; #1;
            check("done_hold", {done, dp_y}, {1'b1, r[7:0]});
        end
        tick(); ack = 1'b1; start = poke; #1;
        check("ack_cycle", outs, mk(0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 1, 0));
        tick(); ack = 1'b0; start = 1'b0; #1;
        check("after_ack", outs, 12'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; ack = 1'b0; x = 8'h33;
        #1;
        check("rst_start_outs", outs, 12'd0);
        tick();
        check("rst_no_load", dp_y, 8'hAA);
        rst = 1'b0; start = 1'b0; #1;
        check("idle_outs", outs, 12'd0);

        run(8'h00, 0, 1'b0, 1'b0);
        check("zero_y", dp_y, 8'h0C);
        run(8'hFF, 0, 1'b0, 1'b0);
        check("ones_y", dp_y, 8'hF3);
        run(8'h55, 10, 1'b0, 1'b0);
        check("alt_y", dp_y, 8'h49);

        force_low = 1'b1;
        tick(); x = 8'h12; start = 1'b1; #1;
        check("wd_start", outs, mk(1, 1, 2'd0, 1, 1, 1, 2'd0, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            tick(); start = 1'b0; #1;
            check("wd_oper", {y_en, s_en, busy, done, err}, 5'b11100);
        end
        tick(); #1;
        check("wd_trip", {y_en, y_store_x, s_en, s_step, done, err}, 7'd0);
        tick(); #1;
        check("wd_err", outs, 12'd1);
        tick(); #1;
        check("wd_idle_err", outs, 12'd1);
        force_low = 1'b0;
        run(8'hA7, 1, 1'b0, 1'b1);

        tick(); x = 8'h3C; start = 1'b1; #1;
        tick(); start = 1'b0; #1;
        tick(); rst = 1'b1; #1;
        check("rst_mid_outs", outs, 12'd0);
        tick(); rst = 1'b0; #1;
        check("rst_mid_idle", outs, 12'd0);
        for (int i = 0; i < 6; i++) begin
            tick(); #1;
            check("rst_no_done", {busy, done}, 2'b00);
        end

        for (int n = 0; n < 8; n++) begin
            run(8'($urandom), int'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_control.md
# seq_control

Control unit for the bit-scan data path: a Moore/Mealy FSM that consumes the data path's status signals `b` (selected bit `y[s]`) and `it_end` (`s == 6`) and produces every control strobe the data path needs. Per run it:
- loads operand `x` into `y`;
- walks `s` over the even bit positions 0, 2, 4, 6;
- at each position updates `y` from the selected bit;
- presents the result with a done/ack handshake.

It sits directly upstream of the data path's control inputs and downstream of its status outputs.

## Interface
Parameters:
- `MAX_STEPS`, default 4: scan steps allowed before the watchdog declares an error.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a run; sampled only in IDLE.
- `ack` in 1: consumer acknowledges the result.
- `b` in 1: data-path status, current `y[s]`.
- `it_end` in 1: data-path status, high when `s == 6`.
- `y_en` out 1: y register write enable.
- `y_store_x` out 1: y input selects `x`.
- `y_select_next` out 2: 0 = hold, 1 = y+1, 2 = y+s, 3 = y−s.
- `s_en` out 1: s register write enable.
- `s_zero` out 1: s base forced to 0.
- `s_add` out 1: 1 = base+step, 0 = base−step.
- `s_step` out 2: s increment.
- `busy` out 1: run in progress (OPER).
- `done` out 1: result valid in the data path's `y`.
- `err` out 1: sticky watchdog error.

## Operation
- States: IDLE, OPER, DONE, ERR. State register and step counter (3 bits) are updated on `posedge clk`. Control strobes are combinational from state and inputs.
- Default strobes in every state: all 0, `y_select_next` = 0, `s_step` = 0.
- **IDLE**
  - If `start` = 0: stay in IDLE.
  - If `start` = 1: assert `y_en` = 1, `y_store_x` = 1, `s_en` = 1, `s_zero` = 1, `s_add` = 1, `s_step` = 0, so `y` ← `x` and `s` ← 0 at this edge. Clear `err` and the step counter. Next state is OPER.
- **OPER**
  - `busy` = 1, `y_en` = 1, `y_select_next` = 3 if `b` = 1, else 2. So `y` ← `y` − `s` or `y` + `s`, mod 256.
  - If `it_end` = 1: `s_en` = 0; next state is DONE.
  - If `it_end` = 0: `s_en` = 1, `s_add` = 1, `s_step` = 2, `s_zero` = 0, so `s` ← `s` + 2. Increment the step counter.
  - If the step counter already equals `MAX_STEPS` and `it_end` = 0: assert no strobes, set `err`, and go to ERR.
- **DONE**
  - `done` = 1; all enables 0, so `y` holds.
  - If `ack` = 1: next state is IDLE. Otherwise stay in DONE, with `done` held high indefinitely.
- **ERR**
  - `err` = 1, all enables 0.
  - Go to IDLE on the next edge. `err` stays high until the next accepted `start`.
- `start` while in OPER or DONE is ignored and not queued.
- Resulting function, given a correctly behaving data path: for s = 0, 2, 4, 6 in order, `y` ← (`y[s]` ? `y` − s : `y` + s) mod 256, with each bit test made on the already-updated `y`.

## Timing
- Reset:
  - While `rst` = 1, all outputs are forced to 0 combinationally. This holds regardless of state and inputs, so no data-path register is written.
  - At the edge: state ← IDLE, step counter ← 0, `err` ← 0.
- Reset mid-run: abort at the next edge and return to IDLE. No `done` is produced for the aborted run.
- Latency:
  - `start` sampled at edge k loads `x` at edge k.
  - OPER occupies the cycles after edges k, k+1, k+2, k+3; the last `y` update happens at edge k+4.
  - `done` is high from edge k+4 onward; the final `y` is visible in the same cycle.
- Throughput: minimum 6 cycles per run with `ack` tied high (IDLE, 4 × OPER, DONE).
- `x` must be stable only during the cycle in which `start` is sampled.
- `ack` while `done` = 0 has no effect. `ack` and `start` in the same DONE cycle: `ack` is taken; `start` is ignored.
- Simultaneous `rst` and `start`: reset wins; no load occurs.

## Test plan
- **Zero operand:** reset, `x` = 0x00, 1-cycle `start` → `y_select_next` sequence 2, 2, 2, 2; `done` rises 4 edges after start; data-path `y` = 0x0C.
- **All ones:** `x` = 0xFF → selects 3, 3, 3, 3; `y` = 0xF3; `busy` is high for exactly 4 cycles.
- **Alternating bits:** `x` = 0x55 → `y` = 0x49. With `ack` held low for 10 cycles, `done` and `y` stay stable; `ack` for 1 cycle → IDLE next edge, `done` = 0.
- **Watchdog:** force `it_end` = 0 permanently → `err` = 1 after 5 OPER cycles and the FSM reaches IDLE. A subsequent `start` clears `err`.
- **Reset and start interactions:**
  - `rst` asserted in the 2nd OPER cycle → all strobes 0 in that cycle, IDLE next, no `done`.
  - `start` pulses during OPER are ignored.
  - `rst` and `start` asserted together → no `y_en`.
